// File: rtl/bpu_pkg.sv
// Shared sizing, PHT counter encodings and the in-flight record type for the branch predict unit.
package bpu_pkg;
    localparam int PC_WIDTH    = 10;
    localparam int HIST_WIDTH  = 3;
    localparam int PC_IDX_BITS = 2;
    localparam int Q_DEPTH     = 4;

    localparam int PHT_IDX_W = PC_IDX_BITS + HIST_WIDTH;
    localparam int PHT_SIZE  = 1 << PHT_IDX_W;
    localparam int Q_PTR_W   = $clog2(Q_DEPTH);

    localparam logic [1:0] SNT = 2'b00;
    localparam logic [1:0] WNT = 2'b01;
    localparam logic [1:0] WT  = 2'b10;
    localparam logic [1:0] ST  = 2'b11;

    typedef logic [Q_PTR_W:0] qcnt_t;

    typedef struct packed {
        logic [PC_WIDTH-1:0]  pc;
        logic                 taken;
        logic [PHT_IDX_W-1:0] idx;
        logic                 train;
    } inflight_t;

    function automatic logic [1:0] sat_update(input logic [1:0] ctr, input logic taken);
        if (taken) return (ctr == ST)  ? ST  : ctr + 2'd1;
        else       return (ctr == SNT) ? SNT : ctr - 2'd1;
    endfunction
endpackage

// File: rtl/branch_predict_unit_pred_queue.sv
// In-order circular FIFO of in-flight predictions; flush empties it by snapping head to tail.
module pred_queue
    import bpu_pkg::*;
(
    input  logic      clk,
    input  logic      rst,
    input  logic      push,
    input  inflight_t push_data,
    input  logic      pop,
    input  logic      flush,
    output inflight_t head,
    output logic      full,
    output logic      empty
);
    inflight_t          mem [Q_DEPTH];
    logic [Q_PTR_W-1:0] rd_ptr, wr_ptr;
    qcnt_t              count;

    assign full  = (count == qcnt_t'(Q_DEPTH));
    assign empty = (count == '0);
    assign head  = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= wr_ptr;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= push_data;
    end
endmodule

// File: rtl/branch_predict_unit.sv
// Direction predictor: PHT of 2-bit counters indexed by {pc low bits, cache history}, with in-order resolve tracking.
module branch_predict_unit
    import bpu_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  predict_req,
    input  logic [PC_WIDTH-1:0]   fetch_pc,
    input  logic                  cache_read_hit,
    input  logic [HIST_WIDTH-1:0] cache_read_history,
    output logic                  predict_valid,
    output logic                  predict_taken,
    output logic                  predict_stall,
    input  logic                  resolve_valid,
    input  logic [PC_WIDTH-1:0]   resolve_pc,
    input  logic                  resolve_taken,
    output logic                  upd_we,
    output logic [PC_WIDTH-1:0]   upd_pc,
    output logic                  upd_taken,
    output logic                  mispredict,
    output logic                  order_error
);
    logic [1:0]           pht [PHT_SIZE];
    inflight_t            head, req_ent;
    logic [PHT_IDX_W-1:0] req_idx;
    logic                 q_full, q_empty;
    logic                 res_ok, res_bad, flush_now, accept;

    assign req_idx = {fetch_pc[PC_IDX_BITS-1:0], cache_read_history};

    // Read is the pre-update counter even when the same index trains this cycle.
    always_comb begin
        req_ent       = '0;
        req_ent.pc    = fetch_pc;
        req_ent.taken = cache_read_hit && pht[req_idx][1];
        req_ent.idx   = req_idx;
        req_ent.train = cache_read_hit;
    end

    assign res_ok        = resolve_valid && !q_empty && (resolve_pc == head.pc);
    assign res_bad       = resolve_valid && !res_ok;
    assign flush_now     = res_ok && (head.taken != resolve_taken);
    assign predict_stall = q_full;
    assign accept        = predict_req && !q_full && !flush_now;

    pred_queue u_queue (
        .clk       (clk),
        .rst       (rst),
        .push      (accept),
        .push_data (req_ent),
        .pop       (res_ok),
        .flush     (flush_now),
        .head      (head),
        .full      (q_full),
        .empty     (q_empty)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < PHT_SIZE; i++) pht[i] <= WNT;
        end else if (res_ok && head.train) begin
            pht[head.idx] <= sat_update(pht[head.idx], resolve_taken);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            predict_valid <= 1'b0;
            predict_taken <= 1'b0;
            upd_we        <= 1'b0;
            upd_pc        <= '0;
            upd_taken     <= 1'b0;
            mispredict    <= 1'b0;
            order_error   <= 1'b0;
        end else begin
            predict_valid <= accept;
            predict_taken <= accept && req_ent.taken;
            upd_we        <= res_ok;
            mispredict    <= flush_now;
            if (res_ok) begin
                upd_pc    <= resolve_pc;
                upd_taken <= resolve_taken;
            end
            if (res_bad) order_error <= 1'b1;
        end
    end
endmodule

// File: tb/tb_branch_predict_unit.sv
// Directed vector table for the test plan, then randomized traffic against a queue/array reference model.
module tb_branch_predict_unit;
    logic       clk = 1'b0;
    logic       rst, predict_req, cache_read_hit, resolve_valid, resolve_taken;
    logic [9:0] fetch_pc, resolve_pc;
    logic [2:0] cache_read_history;
    logic       predict_valid, predict_taken, predict_stall;
    logic       upd_we, upd_taken, mispredict, order_error;
    logic [9:0] upd_pc;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    branch_predict_unit dut (
        .clk(clk), .rst(rst), .predict_req(predict_req), .fetch_pc(fetch_pc),
        .cache_read_hit(cache_read_hit), .cache_read_history(cache_read_history),
        .predict_valid(predict_valid), .predict_taken(predict_taken), .predict_stall(predict_stall),
        .resolve_valid(resolve_valid), .resolve_pc(resolve_pc), .resolve_taken(resolve_taken),
        .upd_we(upd_we), .upd_pc(upd_pc), .upd_taken(upd_taken),
        .mispredict(mispredict), .order_error(order_error)
    );

    typedef struct {
        bit rst, req; logic [9:0] pc; bit hit; logic [2:0] hist;
        bit rv; logic [9:0] rpc; bit rt;
        bit e_stall, e_pv, e_pt, e_we; logic [9:0] e_upc; bit e_ut, e_mis, e_oe;
    } vec_t;

    typedef struct { logic [9:0] pc; bit taken; int idx; bit train; } ent_t;

    function automatic vec_t mk(bit r, bit q, logic [9:0] pc, bit hit, logic [2:0] hist,
                                bit rv, logic [9:0] rpc, bit rt, bit st, bit pv, bit pt,
                                bit we, logic [9:0] upc, bit ut, bit mis, bit oe);
        vec_t v;
        v.rst = r; v.req = q; v.pc = pc; v.hit = hit; v.hist = hist;
        v.rv = rv; v.rpc = rpc; v.rt = rt;
        v.e_stall = st; v.e_pv = pv; v.e_pt = pt; v.e_we = we;
        v.e_upc = upc; v.e_ut = ut; v.e_mis = mis; v.e_oe = oe;
        return v;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic drive(bit r, bit q, logic [9:0] pc, bit hit, logic [2:0] hist,
                         bit rv, logic [9:0] rpc, bit rt);
        rst = r; predict_req = q; fetch_pc = pc; cache_read_hit = hit;
        cache_read_history = hist; resolve_valid = rv; resolve_pc = rpc; resolve_taken = rt;
    endtask

    task automatic check_outs(string tag, bit pv, bit pt, bit we, logic [9:0] upc,
                              bit ut, bit mis, bit oe);
        chk({tag, ".pv"}, 32'(predict_valid), 32'(pv));
        if (pv) chk({tag, ".pt"}, 32'(predict_taken), 32'(pt));
        chk({tag, ".we"}, 32'(upd_we), 32'(we));
        if (we) begin
            chk({tag, ".upc"}, 32'(upd_pc), 32'(upc));
            chk({tag, ".ut"}, 32'(upd_taken), 32'(ut));
        end
        chk({tag, ".mis"}, 32'(mispredict), 32'(mis));
        chk({tag, ".oe"}, 32'(order_error), 32'(oe));
    endtask

    vec_t tbl[$];
    ent_t mq[$];
    int   mpht[32];
    bit   moe;

    initial begin
        // rst req pc hit hist rv rpc rt | stall pv pt we upc ut mis oe
        tbl.push_back(mk(1,0,10'h000,0,3'd0, 0,10'h000,0, 0,0,0,0,10'h000,0,0,0));
        tbl.push_back(mk(0,1,10'h012,1,3'd5, 0,10'h000,0, 0,1,0,0,10'h000,0,0,0)); // ctr21=01
        tbl.push_back(mk(0,0,10'h000,0,3'd0, 1,10'h012,1, 0,0,0,1,10'h012,1,1,0)); // 01->10, flush
        tbl.push_back(mk(0,1,10'h012,1,3'd5, 0,10'h000,0, 0,1,1,0,10'h000,0,0,0));
        tbl.push_back(mk(0,0,10'h000,0,3'd0, 1,10'h012,1, 0,0,0,1,10'h012,1,0,0)); // 10->11
        tbl.push_back(mk(0,1,10'h012,1,3'd5, 0,10'h000,0, 0,1,1,0,10'h000,0,0,0));
        tbl.push_back(mk(0,0,10'h000,0,3'd0, 1,10'h012,1, 0,0,0,1,10'h012,1,0,0)); // stays 11
        tbl.push_back(mk(0,1,10'h012,1,3'd5, 0,10'h000,0, 0,1,1,0,10'h000,0,0,0));
        tbl.push_back(mk(0,0,10'h000,0,3'd0, 1,10'h012,1, 0,0,0,1,10'h012,1,0,0));
        tbl.push_back(mk(0,1,10'h100,0,3'd0, 0,10'h000,0, 0,1,0,0,10'h000,0,0,0)); // fill queue
        tbl.push_back(mk(0,1,10'h101,1,3'd0, 0,10'h000,0, 0,1,0,0,10'h000,0,0,0)); // idx8=01
        tbl.push_back(mk(0,1,10'h102,1,3'd5, 0,10'h000,0, 0,1,1,0,10'h000,0,0,0)); // idx21=11
        tbl.push_back(mk(0,1,10'h103,0,3'd0, 0,10'h000,0, 0,1,0,0,10'h000,0,0,0));
        tbl.push_back(mk(0,1,10'h104,0,3'd0, 0,10'h000,0, 1,0,0,0,10'h000,0,0,0)); // full
        tbl.push_back(mk(0,0,10'h000,0,3'd0, 1,10'h100,0, 1,0,0,1,10'h100,0,0,0));
        tbl.push_back(mk(0,0,10'h000,0,3'd0, 0,10'h000,0, 0,0,0,0,10'h000,0,0,0));
        tbl.push_back(mk(0,1,10'h105,1,3'd0, 1,10'h101,1, 0,0,0,1,10'h101,1,1,0)); // flush drops req
        tbl.push_back(mk(0,1,10'h101,1,3'd0, 0,10'h000,0, 0,1,1,0,10'h000,0,0,0)); // idx8=10
        tbl.push_back(mk(0,0,10'h000,0,3'd0, 1,10'h101,0, 0,0,0,1,10'h101,0,1,0)); // idx8 back to 01
        tbl.push_back(mk(0,1,10'h0A9,0,3'd0, 0,10'h000,0, 0,1,0,0,10'h000,0,0,0)); // miss
        tbl.push_back(mk(0,0,10'h000,0,3'd0, 1,10'h0A9,1, 0,0,0,1,10'h0A9,1,1,0)); // no train
        tbl.push_back(mk(0,1,10'h0A9,1,3'd0, 0,10'h000,0, 0,1,0,0,10'h000,0,0,0)); // idx8 still 01
        tbl.push_back(mk(0,0,10'h000,0,3'd0, 1,10'h0AB,0, 0,0,0,0,10'h000,0,0,1)); // pc mismatch
        tbl.push_back(mk(0,0,10'h000,0,3'd0, 1,10'h0A9,0, 0,0,0,1,10'h0A9,0,0,1)); // sticky
        tbl.push_back(mk(0,0,10'h000,0,3'd0, 1,10'h0A9,0, 0,0,0,0,10'h000,0,0,1)); // empty queue
        tbl.push_back(mk(1,1,10'h012,1,3'd5, 1,10'h0A9,0, 0,0,0,0,10'h000,0,0,0)); // reset wins
        tbl.push_back(mk(0,1,10'h012,1,3'd5, 0,10'h000,0, 0,1,0,0,10'h000,0,0,0)); // PHT back to 01

        drive(1,0,10'h000,0,3'd0,0,10'h000,0);
        repeat (2) @(posedge clk);
        #1;
        chk("reset.pv", 32'(predict_valid), 0);
        chk("reset.stall", 32'(predict_stall), 0);
        chk("reset.oe", 32'(order_error), 0);
        chk("reset.upc", 32'(upd_pc), 0);

        foreach (tbl[i]) begin
            vec_t v;
            v = tbl[i];
            @(negedge clk);
            drive(v.rst, v.req, v.pc, v.hit, v.hist, v.rv, v.rpc, v.rt);
            #1 chk($sformatf("v%0d.stall", i), 32'(predict_stall), 32'(v.e_stall));
            @(posedge clk);
            #1 check_outs($sformatf("v%0d", i), v.e_pv, v.e_pt, v.e_we, v.e_upc, v.e_ut,
                          v.e_mis, v.e_oe);
        end

        moe = 0;
        for (int n = 0; n < 1500; n++) begin
            bit r, q, hit, rv, rt, est, flush, acc, ptk, e_pv, e_pt, e_we, e_ut;
            logic [9:0] pc, rpc, e_upc;
            logic [2:0] hist;
            int idx;
            ent_t h, ne;
            r    = (n == 0) || ($urandom_range(0, 99) < 2);
            q    = $urandom_range(0, 99) < 60;
            pc   = 10'($urandom_range(0, 15));
            hit  = $urandom_range(0, 3) != 0;
            hist = 3'($urandom_range(0, 7));
            rv   = $urandom_range(0, 99) < 45;
            rpc  = (mq.size() > 0 && $urandom_range(0, 9) != 0) ? mq[0].pc
                                                                : 10'($urandom_range(0, 15));
            rt   = 1'($urandom_range(0, 1));
            @(negedge clk);
            drive(r, q, pc, hit, hist, rv, rpc, rt);
            est = (mq.size() == 4);
            if (n > 0) begin
                #1 chk($sformatf("r%0d.stall", n), 32'(predict_stall), 32'(est));
            end
            idx = int'(pc[1:0]) * 8 + int'(hist);
            ptk = hit && (mpht[idx] >= 2);
            e_pv = 0; e_pt = 0; e_we = 0; e_upc = 0; e_ut = 0; flush = 0;
            if (r) begin
                mq.delete();
                foreach (mpht[k]) mpht[k] = 1;
                moe = 0;
            end else begin
                if (rv) begin
                    if (mq.size() == 0 || mq[0].pc != rpc) moe = 1;
                    else begin
                        h = mq.pop_front();
                        if (h.train)
                            mpht[h.idx] = rt ? ((mpht[h.idx] == 3) ? 3 : mpht[h.idx] + 1)
                                             : ((mpht[h.idx] == 0) ? 0 : mpht[h.idx] - 1);
                        e_we = 1; e_upc = rpc; e_ut = rt;
                        flush = (h.taken != rt);
                    end
                end
                acc = q && !est && !flush;
                if (flush) mq.delete();
                else if (acc) begin
                    ne.pc = pc; ne.taken = ptk; ne.idx = idx; ne.train = hit;
                    mq.push_back(ne);
                end
                e_pv = acc; e_pt = ptk;
            end
            @(posedge clk);
            #1 check_outs($sformatf("r%0d", n), e_pv, e_pt, e_we, e_upc, e_ut, flush, moe);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
